// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   - 4-bit opcode constants OP_NOP..OP_MUL
//   - FSM state encoding for the optional iterative multiplier
//   - flag bundle {z,c,n,v} and its reset value
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

  // Flags shown after reset: result is zero, so z is set.
  localparam flags_t FLAGS_RST = '{z: 1'b1, c: 1'b0, n: 1'b0, v: 1'b0};

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
// Only present when ALU_MUL_EN is defined.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start_i    load operands and begin WIDTH iterations (ignored while running)
//   a_i, b_i   multiplicand / multiplier
//   last_o     the step being taken this cycle is the final one (count == 0)
//   prod_o     product including this cycle's step; holds the final product
//              once iteration ends
`ifdef ALU_MUL_EN
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [2*WIDTH-1:0] addend_s;

  // Next-state for one shift-add iteration; the counter runs WIDTH-1 down to 0.
  always_comb begin
    addend_s = mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}};
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i && !run_q) begin
      acc_d    = {(2*WIDTH){1'b0}};
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = SHW'(WIDTH - 1);
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_q + addend_s;
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      if (cnt_q == {SHW{1'b0}}) begin
        run_d = 1'b0;
        cnt_d = cnt_q;
      end else begin
        run_d = 1'b1;
        cnt_d = cnt_q - SHW'(1);
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Multiplier state registers; reset discards any partial product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {SHW{1'b0}};
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  assign last_o = run_q && (cnt_q == {SHW{1'b0}});
  assign prod_o = run_q ? (acc_q + addend_s) : acc_q;

endmodule
`endif

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result/flag stage.
// Optional feature macro: ALU_MUL_EN (opcode 11 = iterative unsigned multiply;
// when undefined opcode 11 behaves as ADD and busy is tied low).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    upstream handshake (x_in, y_in, opr)
//   out_valid / out_ready  downstream handshake (result, z/c/n/v flags)
//   busy                   multiplier iterating
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [3:0]       opr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z_flag,
  output logic             c_flag,
  output logic             n_flag,
  output logic             v_flag,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]  result_q, result_d;
  flags_t            flags_q, flags_d;
  logic              out_valid_q, out_valid_d;

  logic [SHW-1:0]    amt_s;
  logic [WIDTH:0]    sum_s, diff_s, shl_s, shr_s, sra_s;
  logic signed [WIDTH:0] sra_in_s;
  logic [WIDTH-1:0]  op_res_s;
  logic              op_c_s, op_v_s, nop_s;
  logic [WIDTH-1:0]  alu_res_s;
  flags_t            alu_flg_s;

  logic              out_free_s, accept_s, load_s;
  logic [WIDTH-1:0]  load_res_s;
  flags_t            load_flg_s;

  // Single-cycle datapath. Shifts use one extra bit so the last bit shifted
  // out falls into that position (and is 0 for a zero shift amount).
  always_comb begin
    amt_s    = y_in[SHW-1:0];
    sum_s    = {1'b0, x_in} + {1'b0, y_in};
    diff_s   = {1'b0, x_in} + {1'b0, ~y_in} + ONE_X;
    shl_s    = {1'b0, x_in} << amt_s;
    shr_s    = {x_in, 1'b0} >> amt_s;
    sra_in_s = {x_in, 1'b0};
    sra_s    = sra_in_s >>> amt_s;
    nop_s    = 1'b0;
    op_res_s = sum_s[MSB:0];
    op_c_s   = sum_s[WIDTH];
    op_v_s   = (x_in[MSB] == y_in[MSB]) && (sum_s[MSB] != x_in[MSB]);
    case (opr)
      OP_NOP: nop_s = 1'b1;
      OP_ADD: begin
        op_res_s = sum_s[MSB:0];
        op_c_s   = sum_s[WIDTH];
        op_v_s   = (x_in[MSB] == y_in[MSB]) && (sum_s[MSB] != x_in[MSB]);
      end
      OP_SUB: begin
        op_res_s = diff_s[MSB:0];
        op_c_s   = diff_s[WIDTH];
        op_v_s   = (x_in[MSB] != y_in[MSB]) && (diff_s[MSB] != x_in[MSB]);
      end
      OP_AND: begin op_res_s = x_in & y_in; op_c_s = 1'b0; op_v_s = 1'b0; end
      OP_OR:  begin op_res_s = x_in | y_in; op_c_s = 1'b0; op_v_s = 1'b0; end
      OP_XOR: begin op_res_s = x_in ^ y_in; op_c_s = 1'b0; op_v_s = 1'b0; end
      OP_NOT: begin op_res_s = ~x_in;       op_c_s = 1'b0; op_v_s = 1'b0; end
      OP_MOV: begin op_res_s = x_in;        op_c_s = 1'b0; op_v_s = 1'b0; end
      OP_SHL: begin op_res_s = shl_s[MSB:0];   op_c_s = shl_s[WIDTH]; op_v_s = 1'b0; end
      OP_SHR: begin op_res_s = shr_s[WIDTH:1]; op_c_s = shr_s[0];     op_v_s = 1'b0; end
      OP_SRA: begin op_res_s = sra_s[WIDTH:1]; op_c_s = sra_s[0];     op_v_s = 1'b0; end
      // Reserved codes (and MUL when the multiplier is absent) act as ADD.
      default: begin
        op_res_s = sum_s[MSB:0];
        op_c_s   = sum_s[WIDTH];
        op_v_s   = (x_in[MSB] == y_in[MSB]) && (sum_s[MSB] != x_in[MSB]);
      end
    endcase
  end

  // NOP re-presents the held result and flags; everything else derives z/n.
  always_comb begin
    if (nop_s) begin
      alu_res_s = result_q;
      alu_flg_s = flags_q;
    end else begin
      alu_res_s   = op_res_s;
      alu_flg_s.z = (op_res_s == {WIDTH{1'b0}});
      alu_flg_s.c = op_c_s;
      alu_flg_s.n = op_res_s[MSB];
      alu_flg_s.v = op_v_s;
    end
  end

  assign out_free_s = !out_valid_q || out_ready;
  assign accept_s   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  state_e             state_q, state_d;
  logic               mul_start_s, mul_last_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0]   mul_res_s;
  flags_t             mul_flg_s;

  alu_mul_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start_s),
    .a_i     (x_in),
    .b_i     (y_in),
    .last_o  (mul_last_s),
    .prod_o  (mul_prod_s)
  );

  assign in_ready = (state_q == IDLE) && out_free_s;
  assign busy     = (state_q == MUL_BUSY);

  // Multiply flags: carry/overflow flag any nonzero bit in the upper half.
  always_comb begin
    mul_res_s   = mul_prod_s[MSB:0];
    mul_flg_s.z = (mul_prod_s[MSB:0] == {WIDTH{1'b0}});
    mul_flg_s.c = |mul_prod_s[2*WIDTH-1:WIDTH];
    mul_flg_s.n = mul_prod_s[MSB];
    mul_flg_s.v = |mul_prod_s[2*WIDTH-1:WIDTH];
  end

  // Sequencing: IDLE accepts, MUL_BUSY iterates, MUL_WAIT holds a finished
  // product until the output register can take it.
  always_comb begin
    state_d     = state_q;
    load_s      = 1'b0;
    load_res_s  = alu_res_s;
    load_flg_s  = alu_flg_s;
    mul_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s && (opr == OP_MUL)) begin
          mul_start_s = 1'b1;
          state_d     = MUL_BUSY;
        end else if (accept_s) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MUL_BUSY: begin
        load_res_s = mul_res_s;
        load_flg_s = mul_flg_s;
        if (mul_last_s && out_free_s) begin
          load_s  = 1'b1;
          state_d = IDLE;
        end else if (mul_last_s) begin
          state_d = MUL_WAIT;
        end else begin
          state_d = MUL_BUSY;
        end
      end
      MUL_WAIT: begin
        load_res_s = mul_res_s;
        load_flg_s = mul_flg_s;
        if (out_free_s) begin
          load_s  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = MUL_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign in_ready = out_free_s;
  assign busy     = 1'b0;

  // Without the multiplier every accepted op loads the output stage.
  always_comb begin
    load_s     = accept_s;
    load_res_s = alu_res_s;
    load_flg_s = alu_flg_s;
  end
`endif

  // Output stage next-state: a load wins over a drain so throughput is 1/cycle.
  always_comb begin
    if (load_s) begin
      out_valid_d = 1'b1;
      result_d    = load_res_s;
      flags_d     = load_flg_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      result_d    = result_q;
      flags_d     = flags_q;
    end else begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= FLAGS_RST;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign z_flag    = flags_q.z;
  assign c_flag    = flags_q.c;
  assign n_flag    = flags_q.n;
  assign v_flag    = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16). Expected responses are pushed
// into a scoreboard queue at accept time; a monitor pops and compares each
// result when it is consumed (out_valid && out_ready).
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = 16'h0000;
  logic [15:0] y_in = 16'h0000;
  logic [3:0]  opr = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        z_flag, c_flag, n_flag, v_flag, busy;

  // {result, z, c, n, v}
  typedef logic [19:0] exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .opr(opr),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z_flag(z_flag), .c_flag(c_flag),
    .n_flag(n_flag), .v_flag(v_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every consumed result just before the consuming edge.
  always @(negedge clk) begin
    #4;
    if (out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %h with empty scoreboard",
                 {result, z_flag, c_flag, n_flag, v_flag});
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({result, z_flag, c_flag, n_flag, v_flag} !== e) begin
          bad++;
          $display("FAIL result_flags: got %h/zcnv=%b expected %h/zcnv=%b",
                   result, {z_flag, c_flag, n_flag, v_flag}, e[19:4], e[3:0]);
        end
      end
    end
  end

  // Present an op at a falling edge, wait (bounded) for in_ready, then let
  // the accepting rising edge pass. Leaves in_valid low at edge+1.
  task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic rdy, input exp_t e, output int waited);
    waited = 0;
    @(negedge clk);
    opr = op; x_in = x; y_in = y; in_valid = 1'b1; out_ready = rdy;
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", op, waited);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    int nbusy;
    int first;

    // Reset: two cycles high, then check the reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_result", result, 16'h0000);
    chk("rst_z", z_flag, 1'b1);
    chk("rst_c", c_flag, 1'b0);
    chk("rst_n", n_flag, 1'b0);
    chk("rst_v", v_flag, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);

    // Back-to-back directed ops, flags as {z,c,n,v}.
    issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, {16'h8000, 4'b0011}, w);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, {16'h0000, 4'b1100}, w);
    issue(OP_SUB, 16'h0003, 16'h0005, 1'b1, {16'hFFFE, 4'b0010}, w);
    issue(OP_SRA, 16'h8004, 16'h0002, 1'b1, {16'hE001, 4'b0010}, w);
    issue(OP_SHL, 16'h8001, 16'h0001, 1'b1, {16'h0002, 4'b0100}, w);
    issue(OP_SHR, 16'h8003, 16'h0001, 1'b1, {16'h4001, 4'b0100}, w);
    issue(OP_SHL, 16'h00FF, 16'h0010, 1'b1, {16'h00FF, 4'b0000}, w);
    issue(OP_SHR, 16'h8000, 16'h000F, 1'b1, {16'h0001, 4'b0000}, w);
    issue(OP_SRA, 16'h8000, 16'h000F, 1'b1, {16'hFFFF, 4'b0010}, w);
    issue(OP_SUB, 16'h0005, 16'h0003, 1'b1, {16'h0002, 4'b0100}, w);
    issue(OP_SUB, 16'h8000, 16'h0001, 1'b1, {16'h7FFF, 4'b0101}, w);
    issue(OP_XOR, 16'hAAAA, 16'hFFFF, 1'b1, {16'h5555, 4'b0000}, w);
    issue(OP_NOT, 16'hFFFF, 16'h0000, 1'b1, {16'h0000, 4'b1000}, w);
    issue(OP_NOP, 16'h1234, 16'h0001, 1'b1, {16'h0000, 4'b1000}, w);
    issue(OP_MOV, 16'h8000, 16'h0000, 1'b1, {16'h8000, 4'b0010}, w);
    issue(4'd13,  16'h0001, 16'h0002, 1'b1, {16'h0003, 4'b0000}, w);

    // Let the pipeline drain before applying backpressure.
    @(negedge clk);
    out_ready = 1'b1;

    // Backpressure: AND result must hold while out_ready is low.
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, {16'h00F0, 4'b0000}, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_result_held", result, 16'h00F0);
    end
    // Drain and accept on the same edge; OR result visible one cycle later.
    issue(OP_OR, 16'h1200, 16'h0034, 1'b1, {16'h1234, 4'b0000}, w);
    chk("bp_same_edge_accept", w, 0);
    chk("bp_or_valid", out_valid, 1'b1);
    chk("bp_or_result", result, 16'h1234);

`ifdef ALU_MUL_EN
    // MUL 0x0100*0x0200 = 0x20000: low half 0, high half nonzero.
    issue(OP_MUL, 16'h0100, 16'h0200, 1'b1, {16'h0000, 4'b1101}, w);
    nbusy = 0;
    first = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      #1;
      if (cyc == 1) chk("mul_in_ready_low", in_ready, 1'b0);
      if (busy) nbusy++;
      if (out_valid) begin
        first = cyc;
        break;
      end
    end
    chk("mul_busy_cycles", nbusy, 16);
    chk("mul_valid_cycle", first, 17);

    // Reset in the middle of a multiply discards it.
    issue(OP_MUL, 16'h0003, 16'h0005, 1'b1, {16'h000F, 4'b0000}, w);
    repeat (7) @(negedge clk);
    #1;
    chk("mul_busy_mid", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("mul_rst_busy", busy, 1'b0);
    chk("mul_rst_out_valid", out_valid, 1'b0);
    chk("mul_rst_in_ready", in_ready, 1'b1);
    chk("mul_rst_flags", {result, z_flag, c_flag, n_flag, v_flag}, {16'h0000, 4'b1000});

    // Full multiply after recovery, then a plain op.
    issue(OP_MUL, 16'h0003, 16'h0005, 1'b1, {16'h000F, 4'b0000}, w);
    issue(OP_ADD, 16'h0002, 16'h0003, 1'b1, {16'h0005, 4'b0000}, w);
`else
    // Opcode 11 behaves as ADD with latency 1 and no busy.
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b1, {16'hFFFE, 4'b0110}, w);
    chk("op11_latency", out_valid, 1'b1);
    chk("op11_result", result, 16'hFFFE);
    chk("op11_busy", busy, 1'b0);
`endif

    // Wait (bounded) for every expected result to be consumed.
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Adds a registered output stage, valid/ready flow control, a 4-bit opcode space with shifts, a full flag set (Z/C/N/V) and an optional iterative multiplier.
- Sits between the decoder/register-read stage and writeback.
- Upstream stalls via in_ready; downstream applies backpressure via out_ready.

Parameters:
- WIDTH, 16, datapath width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount width, derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept an operation this cycle.
- x_in  in  WIDTH  operand A.
- y_in  in  WIDTH  operand B (low SHW bits are the shift amount for shifts).
- opr  in  4  operation code (see Behaviour).
- out_valid  out  1  result/flags registered and pending.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- z_flag  out  1  result == 0.
- c_flag  out  1  carry / not-borrow / shifted-out bit.
- n_flag  out  1  result[WIDTH-1].
- v_flag  out  1  signed overflow.
- busy  out  1  multiplier iterating.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, result=0, z_flag=1, c_flag=0, n_flag=0, v_flag=0, busy=0, state=IDLE.
  - Reset wins over any in-flight operation; a partial MUL is discarded.
- Accept rule: in_ready = (state==IDLE) && (!out_valid || out_ready). An op is accepted when in_valid && in_ready.
- Single-cycle ops: result and flags register on the accept edge, out_valid=1 next cycle (latency 1).
  - A simultaneous drain and accept gives back-to-back throughput of 1 op/cycle.
- out_valid clears only when out_ready=1 and no new result loads that edge.
- result and flags hold stable while out_valid && !out_ready.
- Opcodes:
  - 0 NOP: result/flags unchanged, but out_valid is still asserted (token passes).
  - 1 ADD: {c,r} = x + y (WIDTH+1 bits); v = (x[MSB]==y[MSB]) && (r[MSB]!=x[MSB]).
  - 2 SUB: {c,r} = x + ~y + 1; c=1 means no borrow (x>=y unsigned); v = (x[MSB]!=y[MSB]) && (r[MSB]!=x[MSB]).
  - 3 AND, 4 OR, 5 XOR, 6 NOT (~x), 7 MOV (x): c=0, v=0.
  - 8 SHL by y[SHW-1:0]: c = last bit shifted out (0 if amount 0); v=0.
  - 9 SHR logical, 10 SRA arithmetic: c = last bit shifted out (0 if amount 0); v=0.
  - 11 MUL: see Optional Feature.
  - 12-15 reserved: behave as ADD.
- z and n are always derived from the new result, except on NOP.
- State machine:
  - IDLE: accept ops; MUL goes to MUL_BUSY, all other ops stay in IDLE.
  - MUL_BUSY: busy=1, in_ready=0; one partial-product step per cycle for WIDTH cycles, count-down from WIDTH-1.
  - At count 0 the result commits; go to IDLE if the output register is free (out_valid=0 or out_ready=1 that cycle), else MUL_WAIT.
  - MUL_WAIT: busy=0, in_ready=0; commit when the output register drains (out_ready=1), then go to IDLE.
- MUL latency: WIDTH+1 cycles from accept to out_valid with no backpressure.
- in_valid while in_ready=0 is ignored; the sender must hold its inputs until accepted.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 11 is an unsigned iterative shift-add multiply.
  - result = low WIDTH bits of the product; c=1 iff the high WIDTH bits are nonzero; v=c.
  - MUL_BUSY/MUL_WAIT, the counter and the accumulator are instantiated.
- Undefined: opcode 11 is treated as reserved (ADD, latency 1).
  - No multiplier state is instantiated; busy is tied 0.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_NOP..OP_MUL (4-bit).
  - FSM state enum {IDLE, MUL_BUSY, MUL_WAIT}.
  - flag struct {z,c,n,v}.
- One sub-module, alu_mul_iter: shift-add multiplier with start/done and a WIDTH-cycle counter, included only under ALU_MUL_EN.
- Combinational op decode and flag generation stay in alu_pipe.

Test Plan:
- rst high 2 cycles, then low -> result=0, z=1, c=n=v=0, out_valid=0, in_ready=1.
- ADD x=0x7FFF, y=0x0001, out_ready=1 -> next cycle result=0x8000, n=1, v=1, c=0, z=0; then ADD 0xFFFF+0x0001 -> result=0, z=1, c=1.
- SUB x=0x0003, y=0x0005 -> result=0xFFFE, c=0, n=1, v=0.
- SRA x=0x8004, y=2 -> result=0xE001, c=0; SHL x=0x8001, y=1 -> result=0x0002, c=1.
- Backpressure: out_ready=0, issue AND 0xF0F0&0x0FF0 -> result=0x00F0 held, in_ready=0 for 5 cycles; raise out_ready with a new OR queued -> drain and accept on the same edge, OR result appears next cycle.
- ALU_MUL_EN, WIDTH=16: MUL 0x0100*0x0200 -> busy=1 for 16 cycles, out_valid at cycle 17, result=0x0000, c=1, v=1; rst at cycle 8 -> busy=0, out_valid=0 next cycle.
